// File: rtl/mat_uart_pkg.sv
// Shared definitions for the matrix-to-UART transmit path: FSM encoding,
// frame header default and element byte-count derivation.
package mat_uart_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_SEND_HDR  = 4'd1;
    localparam logic [3:0] ST_FETCH     = 4'd2;
    localparam logic [3:0] ST_LOAD      = 4'd3;
    localparam logic [3:0] ST_SEND_BYTE = 4'd4;
    localparam logic [3:0] ST_WAIT_TX   = 4'd5;
    localparam logic [3:0] ST_NEXT      = 4'd6;
    localparam logic [3:0] ST_SEND_CHK  = 4'd7;
    localparam logic [3:0] ST_FINISH    = 4'd8;

    typedef enum logic [3:0] {
        IDLE      = ST_IDLE,
        SEND_HDR  = ST_SEND_HDR,
        FETCH     = ST_FETCH,
        LOAD      = ST_LOAD,
        SEND_BYTE = ST_SEND_BYTE,
        WAIT_TX   = ST_WAIT_TX,
        NEXT      = ST_NEXT,
        SEND_CHK  = ST_SEND_CHK,
        FINISH    = ST_FINISH
    } seq_state_t;

    // Which kind of byte is in flight, so WAIT_TX knows where to go next.
    typedef enum logic [1:0] {
        BK_HDR = 2'd0,
        BK_PAY = 2'd1,
        BK_CHK = 2'd2
    } byte_kind_t;

    localparam logic [7:0] HEADER_DEF = 8'hA5;

    function automatic int bytes_of(input int elem_w);
        return elem_w / 8;
    endfunction

endpackage

// File: rtl/mat_tx_sequencer.sv
// Streams a DIM x DIM result matrix as header, MSB-first payload bytes and XOR checksum.
// Latency: header tx_start one cycle after go; element bytes start the cycle after LOAD.
// Backpressure: each byte holds tx_start until tx_busy, then waits for tx_done.
module mat_tx_sequencer
    import mat_uart_pkg::*;
#(
    parameter int          DIM    = 3,
    parameter int          ELEM_W = 16,
    parameter int          ADDR_W = 4,
    parameter logic [7:0]  HEADER = HEADER_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              abort,
    output logic              mat_rd,
    output logic [ADDR_W-1:0] mat_addr,
    input  logic [ELEM_W-1:0] mat_data,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int                BYTES     = bytes_of(ELEM_W);
    localparam int                BCW       = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0]    LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DIM * DIM - 1);

    seq_state_t        state;
    byte_kind_t        kind;
    logic [ELEM_W-1:0] sreg;
    logic [7:0]        chksum;
    logic [BCW-1:0]    byte_cnt;
    logic              abort_q;
    logic              abort_any;
    logic              no_byte_in_flight;

    assign abort_any = abort_q | abort;

    // Points where nothing is on the wire, so an abort can end the frame cleanly.
    assign no_byte_in_flight =
        (state == FETCH) || (state == LOAD) || (state == NEXT) ||
        ((state == SEND_BYTE || state == SEND_CHK) && !tx_start) ||
        (state == WAIT_TX && tx_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            kind     <= BK_HDR;
            sreg     <= '0;
            chksum   <= '0;
            byte_cnt <= '0;
            abort_q  <= 1'b0;
            mat_rd   <= 1'b0;
            mat_addr <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            mat_rd  <= 1'b0;
            if (state != IDLE)
                abort_q <= abort_q | abort;

            if (state != IDLE && abort_any && no_byte_in_flight) begin
                state   <= IDLE;
                busy    <= 1'b0;
                aborted <= 1'b1;
                abort_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (go && !abort) begin
                            state    <= SEND_HDR;
                            busy     <= 1'b1;
                            chksum   <= '0;
                            abort_q  <= 1'b0;
                            mat_addr <= '0;
                            byte_cnt <= '0;
                            kind     <= BK_HDR;
                            tx_data  <= HEADER;
                            tx_start <= 1'b1;
                        end
                    end
                    SEND_HDR: begin
                        if (tx_busy) begin
                            tx_start <= 1'b0;
                            state    <= WAIT_TX;
                        end
                    end
                    SEND_BYTE: begin
                        if (tx_start) begin
                            if (tx_busy) begin
                                tx_start <= 1'b0;
                                state    <= WAIT_TX;
                            end
                        end else begin
                            tx_data  <= sreg[ELEM_W-1 -: 8];
                            sreg     <= sreg << 8;
                            chksum   <= chksum ^ sreg[ELEM_W-1 -: 8];
                            kind     <= BK_PAY;
                            tx_start <= 1'b1;
                        end
                    end
                    SEND_CHK: begin
                        if (tx_start) begin
                            if (tx_busy) begin
                                tx_start <= 1'b0;
                                state    <= WAIT_TX;
                            end
                        end else begin
                            tx_data  <= chksum;
                            kind     <= BK_CHK;
                            tx_start <= 1'b1;
                        end
                    end
                    WAIT_TX: begin
                        if (tx_done) begin
                            case (kind)
                                BK_HDR: begin
                                    state  <= FETCH;
                                    mat_rd <= 1'b1;
                                end
                                BK_PAY: begin
                                    if (byte_cnt == LAST_BYTE) begin
                                        byte_cnt <= '0;
                                        state    <= NEXT;
                                    end else begin
                                        byte_cnt <= byte_cnt + 1'b1;
                                        state    <= SEND_BYTE;
                                    end
                                end
                                BK_CHK: begin
                                    state <= FINISH;
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                end
                                default: state <= IDLE;
                            endcase
                        end
                    end
                    FETCH: state <= LOAD;
                    LOAD: begin
                        // First byte launches straight from the RAM word.
                        tx_data  <= mat_data[ELEM_W-1 -: 8];
                        sreg     <= mat_data << 8;
                        chksum   <= chksum ^ mat_data[ELEM_W-1 -: 8];
                        kind     <= BK_PAY;
                        tx_start <= 1'b1;
                        state    <= SEND_BYTE;
                    end
                    NEXT: begin
                        if (mat_addr == LAST_ADDR) begin
                            state <= SEND_CHK;
                        end else begin
                            mat_addr <= mat_addr + 1'b1;
                            mat_rd   <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                    FINISH:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mat_tx_sequencer.sv
// Randomized bench for mat_tx_sequencer against a frame-level reference model
// with a behavioural UART transmitter and result RAM.
module tb_mat_tx_sequencer;

    localparam int         DIM    = 2;
    localparam int         ELEM_W = 16;
    localparam int         ADDR_W = 4;
    localparam int         NELEM  = DIM * DIM;
    localparam int         BYTES  = ELEM_W / 8;
    localparam logic [7:0] HDR    = 8'hA5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              go;
    logic              abort;
    logic              mat_rd;
    logic [ADDR_W-1:0] mat_addr;
    logic [ELEM_W-1:0] mat_data = '0;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy = 1'b0;
    logic              tx_done = 1'b0;
    logic              busy;
    logic              done;
    logic              aborted;

    mat_tx_sequencer #(.DIM(DIM), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W), .HEADER(HDR)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
        .mat_rd(mat_rd), .mat_addr(mat_addr), .mat_data(mat_data),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
        .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Result RAM: one-cycle read latency, garbage when not read.
    logic [ELEM_W-1:0] ram [0:15];
    always @(posedge clk) begin
        if (mat_rd) mat_data <= ram[mat_addr];
        else        mat_data <= ELEM_W'($urandom);
    end

    // Transmitter: busy rises lat cycles after seeing start, lasts btime cycles, then done.
    int lat   = 1;
    int btime = 4;
    int ph    = 0;
    int cnt   = 0;
    always @(posedge clk) begin
        tx_done <= 1'b0;
        case (ph)
            0: if (tx_start) begin
                if (lat <= 1) begin tx_busy <= 1'b1; cnt <= btime; ph <= 2; end
                else begin cnt <= lat - 1; ph <= 1; end
            end
            1: if (cnt <= 1) begin tx_busy <= 1'b1; cnt <= btime; ph <= 2; end
               else cnt <= cnt - 1;
            default: if (cnt <= 1) begin tx_busy <= 1'b0; tx_done <= 1'b1; ph <= 0; end
                     else cnt <= cnt - 1;
        endcase
    end

    // Passive monitor.
    logic [7:0] byte_q [$];
    int         addr_q [$];
    int         done_cnt = 0, abort_cnt = 0, start_rises = 0;
    int         unstable_cnt = 0, proto_err = 0;
    logic       prev_start = 1'b0;
    logic [7:0] prev_dat = '0;
    always @(negedge clk) begin
        if (done)    done_cnt++;
        if (aborted) abort_cnt++;
        if (mat_rd)  addr_q.push_back(int'(mat_addr));
        if (tx_start && !prev_start) begin
            start_rises++;
            if (tx_busy) proto_err++;
        end
        if (tx_start && prev_start && tx_data != prev_dat) unstable_cnt++;
        if (tx_start && tx_busy) byte_q.push_back(tx_data);
        prev_start = tx_start;
        prev_dat   = tx_data;
    end

    // Reference frame: header, every element MSB-first, XOR of payload.
    logic [7:0] exp_q [$];
    task automatic build_exp();
        logic [7:0] x, b;
        exp_q.delete();
        exp_q.push_back(HDR);
        x = 8'h00;
        for (int e = 0; e < NELEM; e++)
            for (int k = BYTES - 1; k >= 0; k--) begin
                b = 8'((ram[e] >> (8 * k)) & 'hFF);
                exp_q.push_back(b);
                x = x ^ b;
            end
        exp_q.push_back(x);
    endtask

    task automatic check_reset_outs(input string pfx);
        chk_eq({pfx, "_busy"},     busy,     0);
        chk_eq({pfx, "_done"},     done,     0);
        chk_eq({pfx, "_aborted"},  aborted,  0);
        chk_eq({pfx, "_tx_start"}, tx_start, 0);
        chk_eq({pfx, "_mat_rd"},   mat_rd,   0);
        chk_eq({pfx, "_tx_data"},  tx_data,  0);
        chk_eq({pfx, "_mat_addr"}, mat_addr, 0);
    endtask

    task automatic run_frame(input int mid_go);
        int b0, a0, d0, ab0, cyc, n;
        bit fin;
        build_exp();
        @(negedge clk);
        b0 = byte_q.size(); a0 = addr_q.size(); d0 = done_cnt; ab0 = abort_cnt;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk_eq("go_busy",  busy,     1);
        chk_eq("go_start", tx_start, 1);
        chk_eq("go_hdr",   tx_data,  HDR);
        cyc = 0; fin = 0;
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            go  = (mid_go != 0 && cyc == mid_go);
            fin = done || aborted;
        end
        go = 1'b0;
        chk_eq("frame_timeout", fin, 1);
        chk_eq("fin_busy", busy, 0);
        #1;
        chk_eq("done_cnt",  done_cnt - d0,   1);
        chk_eq("abort_cnt", abort_cnt - ab0, 0);
        n = byte_q.size() - b0;
        chk_eq("frame_len", n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++)
            chk_eq($sformatf("byte%0d", i), byte_q[b0 + i], exp_q[i]);
        chk_eq("rd_cnt", addr_q.size() - a0, NELEM);
        for (int i = 0; i < NELEM && a0 + i < addr_q.size(); i++)
            chk_eq($sformatf("addr%0d", i), addr_q[a0 + i], i);
        chk_eq("tx_stable", unstable_cnt, 0);
    endtask

    task automatic wait_bytes(input int b0, input int nb);
        int cyc = 0;
        while (byte_q.size() - b0 < nb && cyc < 3000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk_eq("wait_bytes_timeout", (byte_q.size() - b0 >= nb), 1);
    endtask

    initial begin
        int b0, ab0, d0, s0, cyc;
        rst_n = 1'b0; go = 1'b0; abort = 1'b0;
        for (int i = 0; i < 16; i++) ram[i] = '0;
        repeat (3) @(negedge clk);
        check_reset_outs("rst");
        rst_n = 1'b1;

        // Directed frame, then an immediate second frame.
        ram[0] = 16'h0102; ram[1] = 16'h0304; ram[2] = 16'h0506; ram[3] = 16'h0708;
        build_exp();
        chk_eq("model_chk", exp_q[exp_q.size() - 1], 8'h08);
        run_frame(0);
        run_frame(0);

        // go with abort while idle must do nothing.
        @(negedge clk);
        s0 = start_rises;
        go = 1'b1; abort = 1'b1;
        @(negedge clk);
        go = 1'b0; abort = 1'b0;
        repeat (5) @(negedge clk);
        chk_eq("goabort_busy",   busy, 0);
        chk_eq("goabort_starts", start_rises - s0, 0);

        // Abort while element 1 byte 0 is on the wire.
        build_exp();
        @(negedge clk);
        b0 = byte_q.size(); ab0 = abort_cnt; d0 = done_cnt;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_bytes(b0, 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        cyc = 0;
        while (!aborted && cyc < 3000) begin @(negedge clk); cyc++; end
        chk_eq("abort_seen", aborted, 1);
        #1;
        chk_eq("abort_len", byte_q.size() - b0, 4);
        for (int i = 0; i < 4 && b0 + i < byte_q.size(); i++)
            chk_eq($sformatf("abort_byte%0d", i), byte_q[b0 + i], exp_q[i]);
        s0 = start_rises;
        repeat (30) @(negedge clk);
        chk_eq("abort_pulses",   abort_cnt - ab0, 1);
        chk_eq("abort_no_done",  done_cnt - d0, 0);
        chk_eq("abort_busy",     busy, 0);
        chk_eq("abort_no_start", start_rises - s0, 0);

        // Slow transmitter.
        lat = 3; btime = 9;
        run_frame(0);

        // Asynchronous reset mid-payload, then a clean frame.
        lat = 2; btime = 5;
        @(negedge clk);
        b0 = byte_q.size();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_bytes(b0, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run_frame(0);

        // Randomized frames, some with a stray go mid-frame.
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < NELEM; i++) ram[i] = ELEM_W'($urandom);
            lat   = $urandom_range(1, 4);
            btime = $urandom_range(2, 10);
            run_frame((f % 2 == 1) ? $urandom_range(1, 30) : 0);
        end

        chk_eq("proto_err", proto_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
